// File: rtl/counter_pkg.sv
// Shared definitions for the interval counter and its sequencer: state codes,
// command op codes and the controller FSM encoding.
package counter_pkg;

    localparam logic [7:0] STATE_RESET = 8'd0;
    localparam logic [7:0] STATE_RUN   = 8'd1;
    localparam logic [7:0] STATE_HALT  = 8'd2;

    localparam logic [2:0] OP_CLEAR     = 3'd0;
    localparam logic [2:0] OP_START     = 3'd1;
    localparam logic [2:0] OP_STOP      = 3'd2;
    localparam logic [2:0] OP_SET_INTER = 3'd3;
    localparam logic [2:0] OP_SET_LIMIT = 3'd4;

    typedef enum logic [1:0] {
        StIdle,
        StClr,
        StRun,
        StHalt
    } fsm_e;

    // CLR drives the same code as IDLE so the counter is held cleared.
    function automatic logic [7:0] state_code(input fsm_e s);
        logic [7:0] code;
        code = STATE_RESET;
        case (s)
            StRun:   code = STATE_RUN;
            StHalt:  code = STATE_HALT;
            default: code = STATE_RESET;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/counter_ctrl_if.sv
// Host command handshake into the counter sequencer.
interface counter_ctrl_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready
    );

endinterface

// File: rtl/counter_ctrl.sv
// Command-driven sequencer for the interval counter: decodes host commands,
// runs the clear timer and halts the counter when the programmed limit is hit.
module counter_ctrl
    import counter_pkg::*;
#(
    parameter logic [31:0] DEFAULT_INTER = 32'd9,
    parameter int unsigned CLEAR_CYCLES  = 2
) (
    input  logic           clk,
    input  logic           resetn,
    counter_ctrl_if.slave  cmd,
    input  logic [31:0]    count,
    output logic [7:0]     state,
    output logic [31:0]    inter,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam int unsigned CntW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [CntW-1:0] ClrLoad = CntW'(CLEAR_CYCLES - 1);

    fsm_e            fsm_q, fsm_d;
    logic [CntW-1:0] clr_cnt_q, clr_cnt_d;
    logic [31:0]     limit_q, limit_d;
    logic [31:0]     inter_q, inter_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            ready_q;
    logic [7:0]      state_q;
    logic            busy_q;

    logic accept;
    logic at_limit;

    assign accept   = cmd.cmd_valid & ready_q;
    assign at_limit = (limit_q != 32'd0) && (count >= limit_q);

    always_comb begin
        fsm_d     = fsm_q;
        clr_cnt_d = clr_cnt_q;
        limit_d   = limit_q;
        inter_d   = inter_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        if (fsm_q == StClr) begin
            if (clr_cnt_q == '0) begin
                fsm_d = StIdle;
            end else begin
                clr_cnt_d = clr_cnt_q - CntW'(1);
            end
        end else begin
            if (fsm_q == StRun && at_limit) begin
                fsm_d  = StHalt;
                done_d = 1'b1;
            end
            // A command arriving with an auto-halt sees fsm_d, i.e. the post-halt state.
            if (accept) begin
                case (cmd.cmd_op)
                    OP_CLEAR: begin
                        fsm_d     = StClr;
                        clr_cnt_d = ClrLoad;
                        done_d    = 1'b0;
                    end
                    OP_START: begin
                        if (fsm_d != StRun) begin
                            if (at_limit) begin
                                err_d = 1'b1;
                            end else begin
                                fsm_d = StRun;
                            end
                        end
                    end
                    OP_STOP: begin
                        if (fsm_d == StRun) begin
                            fsm_d = StHalt;
                        end
                    end
                    OP_SET_INTER: begin
                        if (fsm_d == StRun) begin
                            err_d = 1'b1;
                        end else begin
                            inter_d = cmd.cmd_data;
                        end
                    end
                    OP_SET_LIMIT: begin
                        limit_d = cmd.cmd_data;
                    end
                    default: begin
                        err_d = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fsm_q     <= StIdle;
            clr_cnt_q <= '0;
            limit_q   <= 32'd0;
            inter_q   <= DEFAULT_INTER;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ready_q   <= 1'b1;
            state_q   <= STATE_RESET;
            busy_q    <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            clr_cnt_q <= clr_cnt_d;
            limit_q   <= limit_d;
            inter_q   <= inter_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ready_q   <= (fsm_d != StClr);
            state_q   <= state_code(fsm_d);
            busy_q    <= (fsm_d == StRun);
        end
    end

    assign cmd.cmd_ready = ready_q;
    assign state         = state_q;
    assign inter         = inter_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl driving a behavioural interval counter.
module tb_counter_ctrl;
    import counter_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] cnt;
    logic [31:0] div;
    logic [7:0]  state;
    logic [31:0] inter;
    logic        busy, done, err;

    int checks = 0;
    int errors = 0;

    counter_ctrl_if bus ();

    counter_ctrl #(
        .DEFAULT_INTER (32'd9),
        .CLEAR_CYCLES  (2)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .cmd    (bus),
        .count  (cnt),
        .state  (state),
        .inter  (inter),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    // Counter: increments once every inter+1 cycles in RUN, holds in HALT, clears otherwise.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= 32'd0;
            div <= 32'd0;
        end else if (state == STATE_RUN) begin
            if (div >= inter) begin
                div <= 32'd0;
                cnt <= cnt + 32'd1;
            end else begin
                div <= div + 32'd1;
            end
        end else if (state != STATE_HALT) begin
            cnt <= 32'd0;
            div <= 32'd0;
        end
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] data;
        logic [7:0]  st;
        logic [31:0] inter;
        logic        err;
        logic        busy;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Presents one command and returns #1 after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [31:0] data);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL send_ready: got cmd_ready=0 expected 1 within 50 cycles");
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_count(input logic [31:0] target, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (cnt != target && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, cnt, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        logic [31:0] held;

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_data  = 32'd0;

        vecs[0]  = '{OP_SET_INTER, 32'd5, 8'd0, 32'd5, 1'b0, 1'b0};
        vecs[1]  = '{3'd6,         32'd0, 8'd0, 32'd5, 1'b1, 1'b0};
        vecs[2]  = '{OP_STOP,      32'd0, 8'd0, 32'd5, 1'b0, 1'b0};
        vecs[3]  = '{OP_START,     32'd0, 8'd1, 32'd5, 1'b0, 1'b1};
        vecs[4]  = '{OP_START,     32'd0, 8'd1, 32'd5, 1'b0, 1'b1};
        vecs[5]  = '{OP_SET_INTER, 32'd7, 8'd1, 32'd5, 1'b1, 1'b1};
        vecs[6]  = '{OP_SET_LIMIT, 32'd0, 8'd1, 32'd5, 1'b0, 1'b1};
        vecs[7]  = '{3'd7,         32'd0, 8'd1, 32'd5, 1'b1, 1'b1};
        vecs[8]  = '{OP_STOP,      32'd0, 8'd2, 32'd5, 1'b0, 1'b0};
        vecs[9]  = '{OP_SET_INTER, 32'd3, 8'd2, 32'd3, 1'b0, 1'b0};
        vecs[10] = '{OP_START,     32'd0, 8'd1, 32'd3, 1'b0, 1'b1};
        vecs[11] = '{OP_STOP,      32'd0, 8'd2, 32'd3, 1'b0, 1'b0};

        // Reset values, held in reset and after release.
        @(negedge clk);
        check("rst_state", {24'd0, state}, 32'd0);
        check("rst_inter", inter, 32'd9);
        check("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("rst_flags", {29'd0, busy, done, err}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check("idle_state", {24'd0, state}, 32'd0);
        check("idle_inter", inter, 32'd9);
        check("idle_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("idle_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            send(vecs[i].op, vecs[i].data);
            check($sformatf("vec%0d_state", i), {24'd0, state}, {24'd0, vecs[i].st});
            check($sformatf("vec%0d_inter", i), inter, vecs[i].inter);
            check($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].err});
            check($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
        end

        // Asynchronous reset between edges.
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("async_state", {24'd0, state}, 32'd0);
        check("async_inter", inter, 32'd9);
        check("async_ready", {31'd0, bus.cmd_ready}, 32'd1);
        @(negedge clk);
        resetn = 1'b1;

        // Basic run: 40 cycles at inter=3 gives 10 counts.
        send(OP_SET_INTER, 32'd3);
        send(OP_START, 32'd0);
        repeat (39) @(posedge clk);
        send(OP_STOP, 32'd0);
        check("run_count_ok", {31'd0, (cnt == 32'd10 || cnt == 32'd11)}, 32'd1);
        check("run_state", {24'd0, state}, 32'd2);
        held = cnt;
        repeat (20) @(posedge clk);
        #1;
        check("halt_hold", cnt, held);

        // Limit auto-halt.
        send(OP_CLEAR, 32'd0);
        send(OP_SET_INTER, 32'd1);
        send(OP_SET_LIMIT, 32'd5);
        send(OP_START, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("lim_done_pulses", pulses, 32'd1);
        check("lim_state", {24'd0, state}, 32'd2);
        check("lim_count", cnt, 32'd5);
        send(OP_START, 32'd0);
        check("lim_start_err", {31'd0, err}, 32'd1);
        check("lim_start_state", {24'd0, state}, 32'd2);
        @(posedge clk);
        #1;
        check("lim_err_single", {31'd0, err}, 32'd0);

        // CLEAR during RUN with a command held through CLR.
        send(OP_SET_LIMIT, 32'd0);
        send(OP_START, 32'd0);
        repeat (6) @(posedge clk);
        send(OP_CLEAR, 32'd0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_SET_INTER;
        bus.cmd_data  = 32'd4;
        check("clr0_state", {24'd0, state}, 32'd0);
        check("clr0_ready", {31'd0, bus.cmd_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("clr1_state", {24'd0, state}, 32'd0);
        check("clr1_ready", {31'd0, bus.cmd_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("clr2_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("clr2_count", cnt, 32'd0);
        check("clr2_inter", inter, 32'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        check("clr_held_inter", inter, 32'd4);
        check("clr_held_state", {24'd0, state}, 32'd0);

        // Collision: STOP in the cycle the limit is reached.
        send(OP_SET_INTER, 32'd2);
        send(OP_SET_LIMIT, 32'd4);
        send(OP_START, 32'd0);
        wait_count(32'd4, "col_stop_reach");
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_STOP;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        check("col_stop_state", {24'd0, state}, 32'd2);
        check("col_stop_done", {31'd0, done}, 32'd1);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("col_stop_extra", pulses, 32'd0);

        // Collision: CLEAR in the cycle the limit is reached.
        send(OP_CLEAR, 32'd0);
        send(OP_START, 32'd0);
        wait_count(32'd4, "col_clr_reach");
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_CLEAR;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        check("col_clr_state", {24'd0, state}, 32'd0);
        check("col_clr_ready", {31'd0, bus.cmd_ready}, 32'd0);
        pulses = done ? 1 : 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("col_clr_done", pulses, 32'd0);
        check("col_clr_idle", {22'd0, bus.cmd_ready, busy, state}, {22'd0, 1'b1, 1'b0, 8'd0});
        check("col_clr_count", cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
- Command-driven sequencer for the interval counter block. Drives the counter's 8-bit state code (RESET=0, RUN=1, HALT=2) and its 32-bit interval.
- Reads back the counter's 32-bit count and auto-halts when a programmed limit is reached.
- Sits between the host command path and the counter; it is the only source of the counter's state and interval inputs.

Parameters:
- DEFAULT_INTER, 32'd9, interval value loaded at reset.
- CLEAR_CYCLES, 2, cycles RESET is held on a CLEAR command (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command can be accepted this cycle.
- cmd_op  in  3  0=CLEAR, 1=START, 2=STOP, 3=SET_INTER, 4=SET_LIMIT, 5-7 illegal.
- cmd_data  in  32  operand for SET_INTER/SET_LIMIT.
- count  in  32  counter output, fed back.
- state  out  8  state code to counter.
- inter  out  32  interval to counter.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse on limit auto-halt.
- err  out  1  one-cycle pulse on rejected or illegal command.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is asynchronous, active-low, on `resetn`. Every register clears on `resetn`=0 regardless of `clk`.
- Values while in reset:
  - FSM=IDLE, state=0, inter=DEFAULT_INTER, limit=0.
  - cmd_ready=1.
  - busy=0, done=0, err=0.
- All outputs are registered.
- Handshake:
  - A command is accepted on a rising edge where cmd_valid&cmd_ready.
  - Effects appear on outputs the next cycle (latency 1).
  - Commands are not queued. Nothing is captured while cmd_ready=0, and the host must hold cmd_valid.
- FSM states and their state output:
  - IDLE → state=0.
  - CLR → state=0.
  - RUN → state=1.
  - HALT → state=2.
- CLEAR (any FSM state):
  - Go to CLR and load clr_cnt=CLEAR_CYCLES-1. cmd_ready=0 while in CLR.
  - Decrement clr_cnt each cycle. At 0, go to IDLE and set cmd_ready=1.
  - Net effect: state=0 is held for exactly CLEAR_CYCLES cycles.
- START:
  - IDLE or HALT → RUN.
  - In RUN: no-op, no err.
  - Rejected with err if limit!=0 and count>=limit (FSM unchanged).
- STOP:
  - RUN → HALT.
  - IDLE or HALT: no-op.
- SET_INTER: inter<=cmd_data only in IDLE or HALT. In RUN it is rejected with err and inter is unchanged.
- SET_LIMIT: limit<=cmd_data in any non-CLR state. limit=0 means unlimited.
- Illegal op: err pulse, no other effect.
- Auto-halt:
  - Condition: FSM in RUN, limit!=0 and count>=limit (unsigned compare).
  - Next cycle: FSM=HALT and done=1 for exactly one cycle.
  - Because of the one-cycle latency, count may overshoot limit by at most 1 (only possible when inter=0). This is accepted.
- Simultaneous auto-halt and an accepted command in the same cycle:
  - CLEAR wins; no done pulse.
  - STOP → HALT with done=1.
  - Any other command is processed against the post-halt state, i.e. treated as issued in HALT.
- Pulses: err and done are single-cycle and never stretched. Back-to-back rejected commands give back-to-back err pulses.
- Reset mid-operation: immediate return to reset values; an in-progress CLR sequence is abandoned.
- busy = (FSM==RUN), registered.

Decomposition:
- Shared package (counter_pkg) holds:
  - state code constants STATE_RESET=8'd0, STATE_RUN=8'd1, STATE_HALT=8'd2, shared with the counter.
  - op code constants OP_CLEAR through OP_SET_LIMIT.
  - the FSM state encoding.
- No sub-module. The decoder, FSM, clear timer and limit compare stay in one module.
- Bench instantiates counter_ctrl together with the counter, count→count, state/inter→counter.

Test Plan:
- Reset then idle: resetn low 3 cycles, release → state=0, inter=9, cmd_ready=1, busy=0. Async check: assert resetn between edges → outputs clear before the next edge.
- Basic run: SET_INTER 3, START, wait 40 cycles, STOP → count=10 at STOP (+/-1 per STOP timing), state=2. Hold 20 cycles → count unchanged.
- Limit auto-halt: SET_INTER 1, SET_LIMIT 5, START → done pulses once, state=2, count=5. Further START → err=1, state stays 2.
- CLEAR during RUN with CLEAR_CYCLES=2: state=0 for exactly 2 cycles, cmd_ready=0 for 2 cycles, then IDLE and count=0. A cmd_valid held through CLR is accepted on the first ready cycle.
- Rejections: SET_INTER 7 while RUN → err pulse, inter unchanged. op=6 → err pulse, no state change. START while RUN → no err.
- Collision: limit=4, inter=2, issue STOP in the exact cycle count reaches 4 → HALT and a single done pulse. Repeat with CLEAR → IDLE, no done.
